// File: rtl/fu_issue_arbiter_pkg.sv
// Shared CDB/reservation-station types for the functional-unit issue arbiter.
// Provides the reservation-station payload, the branch-dependency mask, the
// arbiter state encoding and a helper that tests an op against a recovery.
package fu_issue_arbiter_pkg;

   localparam int EBR_NUM   = 4;
   localparam int ROB_DEPTH = 16;
   localparam int EBR_IDX_W = $clog2(EBR_NUM);
   localparam int ROB_TAG_W = $clog2(ROB_DEPTH) + 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } arb_state_t;

   // Per-branch-slot dependency: which unresolved branches this op sits behind.
   typedef struct packed {
      logic [EBR_NUM-1:0]                valid;
      logic [EBR_NUM-1:0][ROB_TAG_W-1:0] rob_tags;
   } depen_t;

   typedef struct packed {
      logic [3:0]           opcode;
      logic [31:0]          src1;
      logic [31:0]          src2;
      logic [ROB_TAG_W-1:0] rob_tag;
      depen_t               depen;
   } res_station_t;

   // True when the op depends on the branch being recovered in slot idx.
   function automatic logic depen_hit(input depen_t d,
                                      input logic [EBR_IDX_W-1:0] idx,
                                      input logic [ROB_TAG_W-1:0] tag);
      return d.valid[idx] && (d.rob_tags[idx] == tag);
   endfunction

endpackage

// File: rtl/fu_issue_arbiter_if.sv
// Handshake bundle between the reservation stations / CDB and the arbiter.
//   slave  : arbiter side (consumes req/in_*, cdb_ack, flush; drives grant/fu_*)
//   master : environment side (stations, CDB, branch recovery)
interface fu_issue_arbiter_if
   import fu_issue_arbiter_pkg::*;
#(
   parameter int REQ_NUM = 4
);
   logic [REQ_NUM-1:0]                req;
   logic [REQ_NUM-1:0]                grant;
   logic [REQ_NUM-1:0]                in_valid;
   res_station_t [REQ_NUM-1:0]        in_op;
   logic                              fu_busy;
   res_station_t                      fu_op;
   logic                              result_valid;
   logic                              cdb_ack;
   logic                              early_flush;
   logic [EBR_IDX_W-1:0]              recover_idx;
   logic [ROB_TAG_W-1:0]              depen_rob;

   modport slave (
      input  req, in_valid, in_op, cdb_ack, early_flush, recover_idx, depen_rob,
      output grant, fu_busy, fu_op, result_valid
   );

   modport master (
      output req, in_valid, in_op, cdb_ack, early_flush, recover_idx, depen_rob,
      input  grant, fu_busy, fu_op, result_valid
   );
endinterface

// File: rtl/fu_issue_arbiter_rr_picker.sv
// Combinational round-robin picker.
//   req_i       : request vector
//   rr_ptr_i    : highest-priority index this round
//   pick_o      : one-hot winner (0 when nothing requested)
//   any_valid_o : at least one request present
// The request vector is doubled and shifted down by rr_ptr so a plain
// lowest-bit priority search implements the wrap-around order.
module fu_issue_arbiter_rr_picker #(
   parameter int REQ_NUM = 4
) (
   input  logic [REQ_NUM-1:0]         req_i,
   input  logic [$clog2(REQ_NUM)-1:0] rr_ptr_i,
   output logic [REQ_NUM-1:0]         pick_o,
   output logic                       any_valid_o
);
   localparam int PTR_W = $clog2(REQ_NUM);
   localparam int SUM_W = PTR_W + 1;

   logic [REQ_NUM-1:0] rot_s;
   logic [PTR_W-1:0]   off_s;
   logic [SUM_W-1:0]   sum_s;
   logic [PTR_W-1:0]   sel_s;

   // Rotated priority search, then map the offset back to a station index.
   always_comb begin
      rot_s       = REQ_NUM'({req_i, req_i} >> rr_ptr_i);
      any_valid_o = |req_i;
      off_s       = '0;
      for (int j = REQ_NUM - 1; j >= 0; j--) begin
         if (rot_s[j]) begin
            off_s = PTR_W'(j);
         end else begin
            off_s = off_s;
         end
      end
      sum_s = {1'b0, off_s} + {1'b0, rr_ptr_i};
      if (sum_s >= SUM_W'(REQ_NUM)) begin
         sum_s = sum_s - SUM_W'(REQ_NUM);
      end else begin
         sum_s = sum_s;
      end
      sel_s  = sum_s[PTR_W-1:0];
      pick_o = '0;
      if (any_valid_o) begin
         pick_o[sel_s] = 1'b1;
      end else begin
         pick_o = '0;
      end
   end

endmodule

// File: rtl/fu_issue_arbiter.sv
// Issue arbiter for one shared non-pipelined multi-cycle functional unit.
//   clk, rst : clock, synchronous active-high reset
//   bus_if   : slave side of fu_issue_arbiter_if
//              grant        - one-hot ready back to the winning station
//              fu_busy      - unit occupied (BUSY or DONE)
//              fu_op        - captured operation ('0 when idle)
//              result_valid - result offered to the CDB until cdb_ack
// An in-flight op whose branch dependency matches an early_flush is dropped.
module fu_issue_arbiter
   import fu_issue_arbiter_pkg::*;
#(
   parameter int REQ_NUM = 4,
   parameter int LATENCY = 3
) (
   input logic                 clk,
   input logic                 rst,
   fu_issue_arbiter_if.slave   bus_if
);
   localparam int PTR_W = $clog2(REQ_NUM);
   localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   arb_state_t       state_q, state_d;
   logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   res_station_t     op_q, op_d;

   logic [REQ_NUM-1:0] pick_s;
   logic               any_valid_s;
   logic [REQ_NUM-1:0] grant_s;
   logic [PTR_W-1:0]   win_idx_s;
   logic               grant_en_s;
   logic               capture_s;
   logic               kill_s;

   fu_issue_arbiter_rr_picker #(.REQ_NUM(REQ_NUM)) u_picker (
      .req_i       (bus_if.req),
      .rr_ptr_i    (rr_ptr_q),
      .pick_o      (pick_s),
      .any_valid_o (any_valid_s)
   );

   // Encode the one-hot pick into the index used for capture and rr update.
   always_comb begin
      win_idx_s = '0;
      for (int i = 0; i < REQ_NUM; i++) begin
         if (pick_s[i]) begin
            win_idx_s = PTR_W'(i);
         end else begin
            win_idx_s = win_idx_s;
         end
      end
   end

   // Grant, kill detection, next-state and datapath updates.
   always_comb begin
      state_d  = state_q;
      rr_ptr_d = rr_ptr_q;
      cnt_d    = cnt_q;
      op_d     = op_q;

      // grant never looks at in_valid, so no in_valid->grant loop exists
      grant_en_s = ((state_q == IDLE) || ((state_q == DONE) && bus_if.cdb_ack))
                   && !bus_if.early_flush;
      grant_s    = (grant_en_s && any_valid_s) ? pick_s : '0;
      capture_s  = |(grant_s & bus_if.in_valid);
      kill_s     = (state_q != IDLE) && bus_if.early_flush
                   && depen_hit(op_q.depen, bus_if.recover_idx, bus_if.depen_rob);

      case (state_q)
         IDLE: begin
            if (capture_s) begin
               state_d = BUSY;
            end else begin
               state_d = IDLE;
            end
         end
         BUSY: begin
            if (kill_s) begin
               state_d = IDLE;
               op_d    = '0;
            end else if (cnt_q == '0) begin
               state_d = DONE;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         DONE: begin
            // kill outranks cdb_ack; capture here implies cdb_ack
            if (kill_s) begin
               state_d = IDLE;
               op_d    = '0;
            end else if (capture_s) begin
               state_d = BUSY;
            end else if (bus_if.cdb_ack) begin
               state_d = IDLE;
               op_d    = '0;
            end else begin
               state_d = DONE;
            end
         end
         default: begin
            state_d = IDLE;
            op_d    = '0;
         end
      endcase

      if (capture_s) begin
         op_d     = bus_if.in_op[win_idx_s];
         cnt_d    = CNT_W'(LATENCY - 1);
         rr_ptr_d = (win_idx_s == PTR_W'(REQ_NUM - 1)) ? '0 : win_idx_s + PTR_W'(1);
      end else begin
         rr_ptr_d = rr_ptr_d;
      end

      bus_if.grant        = grant_s;
      bus_if.fu_busy      = (state_q != IDLE);
      bus_if.fu_op        = op_q;
      bus_if.result_valid = (state_q == DONE) && !kill_s;
   end

   // State, round-robin pointer, latency counter and captured op.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         rr_ptr_q <= '0;
         cnt_q    <= '0;
         op_q     <= '0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         cnt_q    <= cnt_d;
         op_q     <= op_d;
      end
   end

endmodule

// File: tb/tb_fu_issue_arbiter.sv
module tb_fu_issue_arbiter;
   import fu_issue_arbiter_pkg::*;

   logic clk;
   logic rst;
   logic [3:0] iv_mask;
   int n_tests;
   int n_fail;
   res_station_t exp_q[$];
   res_station_t mon_e;

   fu_issue_arbiter_if #(.REQ_NUM(4)) bus ();

   fu_issue_arbiter #(.REQ_NUM(4), .LATENCY(3)) dut (
      .clk    (clk),
      .rst    (rst),
      .bus_if (bus.slave)
   );

   // station model: out_valid = ready & head valid (maskable)
   assign bus.in_valid = bus.grant & bus.req & iv_mask;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic res_station_t mk_op(input logic [3:0] id, input logic [1:0] didx,
                                          input logic [4:0] tag);
      res_station_t o;
      o = '0;
      o.opcode = id;
      o.src1 = 32'hA000_0000 | 32'(id);
      o.src2 = 32'h0000_5A00 + 32'(id);
      o.rob_tag = 5'(id) + 5'd8;
      o.depen.valid[didx] = 1'b1;
      o.depen.rob_tags[didx] = tag;
      return o;
   endfunction

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   // wait (bounded) for result_valid, then ack it for one cycle
   task automatic drain();
      int k;
      k = 0;
      while (!bus.result_valid && k < 20) begin
         nxt();
         k++;
      end
      if (!bus.result_valid) begin
         n_tests++;
         n_fail++;
         $display("FAIL drain_timeout: got result_valid=0 expected 1");
      end
      bus.cdb_ack = 1'b1;
      nxt();
      bus.cdb_ack = 1'b0;
   endtask

   // scoreboard monitor: every accepted result must match the next expected op
   always @(negedge clk) begin
      if (!rst && bus.result_valid && bus.cdb_ack) begin
         if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_result: got %h expected none", bus.fu_op);
         end else begin
            mon_e = exp_q.pop_front();
            chk("result_op", 128'(bus.fu_op), 128'(mon_e));
         end
      end
   end

   initial begin
      int seen;
      logic [3:0] exp_g;
      n_tests = 0;
      n_fail = 0;
      rst = 1'b1;
      iv_mask = 4'b1111;
      bus.req = 4'b0000;
      bus.cdb_ack = 1'b0;
      bus.early_flush = 1'b0;
      bus.recover_idx = 2'd0;
      bus.depen_rob = 5'd0;
      for (int s = 0; s < 4; s++) bus.in_op[s] = mk_op(4'(s + 1), 2'd0, 5'(s));

      // reset state
      nxt();
      nxt();
      #3;
      chk("rst_grant", 128'(bus.grant), 128'(4'b0000));
      chk("rst_busy", 128'(bus.fu_busy), 128'(1'b0));
      chk("rst_rv", 128'(bus.result_valid), 128'(1'b0));
      chk("rst_op", 128'(bus.fu_op), 128'(0));
      nxt();
      rst = 1'b0;

      // first issue and latency
      bus.req = 4'b0101;
      #3;
      chk("grant_first", 128'(bus.grant), 128'(4'b0001));
      exp_q.push_back(bus.in_op[0]);
      nxt();
      bus.req = 4'b0000;
      for (int k = 1; k <= 3; k++) begin
         #3;
         chk("busy_lat", 128'({bus.fu_busy, bus.result_valid}), 128'(2'b10));
         nxt();
      end
      // CDB backpressure: 5 cycles in DONE without ack
      bus.req = 4'b0010;
      for (int k = 0; k < 5; k++) begin
         #3;
         chk("bp_rv", 128'(bus.result_valid), 128'(1'b1));
         chk("bp_op", 128'(bus.fu_op), 128'(mk_op(4'd1, 2'd0, 5'd0)));
         chk("bp_grant", 128'(bus.grant), 128'(4'b0000));
         nxt();
      end
      bus.cdb_ack = 1'b1;
      #3;
      chk("ack_grant", 128'(bus.grant), 128'(4'b0010));
      exp_q.push_back(bus.in_op[1]);
      nxt();
      bus.cdb_ack = 1'b0;
      bus.req = 4'b0000;
      #3;
      chk("b2b_busy", 128'({bus.fu_busy, bus.result_valid}), 128'(2'b10));
      chk("b2b_op", 128'(bus.fu_op), 128'(mk_op(4'd2, 2'd0, 5'd1)));
      drain();

      // fairness after reset: rotation 0,1,2,3,0 with ack tied high
      rst = 1'b1;
      nxt();
      rst = 1'b0;
      bus.req = 4'b1111;
      bus.cdb_ack = 1'b1;
      for (int c = 0; c <= 16; c++) begin
         #3;
         exp_g = (c % 4 == 0) ? (4'b0001 << ((c / 4) % 4)) : 4'b0000;
         chk("rr_grant", 128'(bus.grant), 128'(exp_g));
         if (c % 4 == 0) exp_q.push_back(bus.in_op[(c / 4) % 4]);
         nxt();
      end
      bus.req = 4'b0000;
      bus.cdb_ack = 1'b0;
      drain();

      // flush kill: matching tag (rr_ptr now 1)
      bus.in_op[2] = mk_op(4'd9, 2'd2, 5'd5);
      bus.req = 4'b0100;
      #3;
      chk("kill_grant", 128'(bus.grant), 128'(4'b0100));
      nxt();
      bus.req = 4'b0000;
      nxt();
      bus.early_flush = 1'b1;
      bus.recover_idx = 2'd2;
      bus.depen_rob = 5'd5;
      #3;
      chk("kill_cycle_rv", 128'(bus.result_valid), 128'(1'b0));
      nxt();
      bus.early_flush = 1'b0;
      #3;
      chk("kill_idle", 128'({bus.fu_busy, bus.result_valid}), 128'(2'b00));
      chk("kill_op", 128'(bus.fu_op), 128'(0));
      seen = 0;
      bus.cdb_ack = 1'b1;
      for (int k = 0; k < 6; k++) begin
         nxt();
         if (bus.result_valid) seen++;
      end
      bus.cdb_ack = 1'b0;
      chk("kill_no_result", 128'(seen), 128'(0));

      // flush with non-matching tag: result still delivered (rr_ptr now 3)
      bus.req = 4'b0100;
      #3;
      chk("nokill_grant", 128'(bus.grant), 128'(4'b0100));
      exp_q.push_back(bus.in_op[2]);
      nxt();
      bus.req = 4'b0000;
      nxt();
      bus.early_flush = 1'b1;
      bus.depen_rob = 5'd6;
      nxt();
      bus.early_flush = 1'b0;
      #3;
      chk("nokill_busy", 128'(bus.fu_busy), 128'(1'b1));
      drain();

      // flush at a grant opportunity blocks grant for that cycle only
      bus.req = 4'b0010;
      bus.early_flush = 1'b1;
      #3;
      chk("flush_grant", 128'(bus.grant), 128'(4'b0000));
      nxt();
      bus.early_flush = 1'b0;
      #3;
      chk("flush_nocap", 128'(bus.fu_busy), 128'(1'b0));
      chk("flush_regrant", 128'(bus.grant), 128'(4'b0010));
      exp_q.push_back(bus.in_op[1]);
      nxt();
      bus.req = 4'b0000;
      drain();

      // reset in the middle of an operation (rr_ptr now 2)
      bus.req = 4'b0001;
      nxt();
      bus.req = 4'b0000;
      #3;
      chk("pre_rst_busy", 128'(bus.fu_busy), 128'(1'b1));
      nxt();
      rst = 1'b1;
      nxt();
      rst = 1'b0;
      bus.req = 4'b1111;
      #3;
      chk("mid_rst_state", 128'({bus.fu_busy, bus.result_valid}), 128'(2'b00));
      chk("mid_rst_op", 128'(bus.fu_op), 128'(0));
      chk("mid_rst_rr", 128'(bus.grant), 128'(4'b0001));
      exp_q.push_back(bus.in_op[0]);
      nxt();
      bus.req = 4'b0000;
      drain();

      // granted station without in_valid: no capture, rr_ptr kept (rr_ptr 1)
      iv_mask = 4'b0000;
      bus.req = 4'b0010;
      #3;
      chk("noiv_grant", 128'(bus.grant), 128'(4'b0010));
      nxt();
      iv_mask = 4'b1111;
      #3;
      chk("noiv_idle", 128'(bus.fu_busy), 128'(1'b0));
      chk("noiv_regrant", 128'(bus.grant), 128'(4'b0010));
      exp_q.push_back(bus.in_op[1]);
      nxt();
      bus.req = 4'b0000;
      drain();

      nxt();
      chk("queue_empty", 128'(exp_q.size()), 128'(0));
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
